// File: rtl/lu_row_store_pkg.sv
// ============================================================================
// Module : lu_pkg
// Shared types for the LU row store: complex FP64 element and FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lu_pkg;

  typedef struct packed {
    logic [63:0] im;
    logic [63:0] re;
  } cplx_t;

  localparam int CPLX_W = $bits(cplx_t);

  localparam logic [63:0] FP64_ONE = 64'h3ff0000000000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2,
    DRAIN = 2'd3
  } row_store_state_t;

endpackage

`default_nettype wire

// File: rtl/lu_row_store_if.sv
// ============================================================================
// Module : lu_row_store_if
// Load, engine read/writeback and drain signals of the LU row store.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface lu_row_store_if
  import lu_pkg::*;
#(
  parameter int SIZE = 16
) ();

  localparam int AW = $clog2(SIZE);
  localparam int RW = SIZE * CPLX_W;

  logic          start_i;
  logic [RW-1:0] in_row_i;
  logic          in_row_valid_i;
  logic          in_row_ready_o;
  logic [AW-1:0] rd_addr_i;
  logic          rd_addr_valid_i;
  logic [RW-1:0] rd_row_o;
  logic          rd_row_valid_o;
  logic [AW-1:0] rd_row_addr_o;
  logic [RW-1:0] wr_row_i;
  logic          wr_row_valid_i;
  logic [AW-1:0] wr_addr_i;
  logic          wr_ready_o;
  logic          lu_start_o;
  logic          lu_done_i;
  logic [RW-1:0] out_row_o;
  logic          out_row_valid_o;
  logic [AW-1:0] out_row_addr_o;
  logic          out_row_ready_i;
  logic          busy_o;

  modport slave (
    input  start_i, in_row_i, in_row_valid_i, rd_addr_i, rd_addr_valid_i,
           wr_row_i, wr_row_valid_i, wr_addr_i, lu_done_i, out_row_ready_i,
    output in_row_ready_o, rd_row_o, rd_row_valid_o, rd_row_addr_o,
           wr_ready_o, lu_start_o, out_row_o, out_row_valid_o,
           out_row_addr_o, busy_o
  );

  modport master (
    output start_i, in_row_i, in_row_valid_i, rd_addr_i, rd_addr_valid_i,
           wr_row_i, wr_row_valid_i, wr_addr_i, lu_done_i, out_row_ready_i,
    input  in_row_ready_o, rd_row_o, rd_row_valid_o, rd_row_addr_o,
           wr_ready_o, lu_start_o, out_row_o, out_row_valid_o,
           out_row_addr_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/lu_row_store_ram.sv
// ============================================================================
// Module : lu_row_ram
// SIZE x row-wide 1R1W memory, registered read (read-first), no reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lu_row_ram #(
  parameter int SIZE = 16,
  parameter int RW   = SIZE * 128,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [RW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [RW-1:0] rdata_o
);

  logic [RW-1:0] mem_q [0:SIZE-1];
  logic [RW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/lu_row_store.sv
// ============================================================================
// Module : lu_row_store
// Row store between input DMA and the LU engine: load, serve, drain.
// Option : LU_ROW_STORE_WR_BYPASS_EN selects write-first read collisions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lu_row_store
  import lu_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  lu_row_store_if.slave bus
);

  localparam int AW = $clog2(SIZE);
  localparam int RW = SIZE * CPLX_W;
  localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_LOAD  = LOAD;
  localparam logic [1:0] S_SERVE = SERVE;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] load_cnt_q, load_cnt_d;
  logic [AW-1:0] drain_cnt_q, drain_cnt_d;
  logic          lu_start_q, lu_start_d;
  logic          out_valid_q, out_valid_d;
  logic          rd_valid_q;
  logic [AW-1:0] rd_addr_q;

  logic          load_acc, drain_acc, rd_req, wr_req;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [RW-1:0] ram_wdata, ram_rdata, rd_data;

  assign load_acc  = (state_q == S_LOAD) && bus.in_row_valid_i;
  assign drain_acc = out_valid_q && bus.out_row_ready_i;
  assign rd_req    = (state_q == S_SERVE) && bus.rd_addr_valid_i;
  assign wr_req    = (state_q == S_SERVE) && bus.wr_row_valid_i;

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    lu_start_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d    = S_LOAD;
          load_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (load_acc) begin
          load_cnt_d = load_cnt_q + AW'(1);
          if (load_cnt_q == LAST) begin
            state_d    = S_SERVE;
            lu_start_d = 1'b1;
          end
        end
      end
      S_SERVE: begin
        if (bus.lu_done_i) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        out_valid_d = 1'b1;
        if (drain_acc) begin
          drain_cnt_d = drain_cnt_q + AW'(1);
          if (drain_cnt_q == LAST) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      lu_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      lu_start_q  <= lu_start_d;
      out_valid_q <= out_valid_d;
      rd_valid_q  <= rd_req;
      if (rd_req) begin
        rd_addr_q <= bus.rd_addr_i;
      end
    end
  end

  // In DRAIN the read port pre-fetches the next count so accepted rows
  // are replaced by the following row without a bubble.
  assign ram_raddr = (state_q == S_DRAIN) ? drain_cnt_d : bus.rd_addr_i;
  assign ram_we    = load_acc || wr_req;
  assign ram_waddr = (state_q == S_LOAD) ? load_cnt_q : bus.wr_addr_i;
  assign ram_wdata = (state_q == S_LOAD) ? bus.in_row_i : bus.wr_row_i;

  lu_row_ram #(
    .SIZE (SIZE),
    .RW   (RW),
    .AW   (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

`ifdef LU_ROW_STORE_WR_BYPASS_EN
  logic          byp_q;
  logic [RW-1:0] byp_row_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byp_q     <= 1'b0;
      byp_row_q <= '0;
    end else begin
      byp_q     <= rd_req && wr_req && (bus.rd_addr_i == bus.wr_addr_i);
      byp_row_q <= bus.wr_row_i;
    end
  end

  assign rd_data = byp_q ? byp_row_q : ram_rdata;
`else
  assign rd_data = ram_rdata;
`endif

  // The RAM is never reset; data outputs are gated by their valids.
  assign bus.rd_row_o        = rd_valid_q ? rd_data : '0;
  assign bus.rd_row_valid_o  = rd_valid_q;
  assign bus.rd_row_addr_o   = rd_addr_q;
  assign bus.out_row_o       = out_valid_q ? ram_rdata : '0;
  assign bus.out_row_valid_o = out_valid_q;
  assign bus.out_row_addr_o  = drain_cnt_q;
  assign bus.in_row_ready_o  = (state_q == S_LOAD);
  assign bus.wr_ready_o      = (state_q == S_SERVE);
  assign bus.lu_start_o      = lu_start_q;
  assign bus.busy_o          = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lu_row_store.sv
// ============================================================================
// Module : tb_lu_row_store
// Self-checking bench for lu_row_store (SIZE=4) against a row-array model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lu_row_store;

  localparam int SIZE = 4;
  localparam int AW   = 2;
  localparam int RW   = SIZE * 128;
`ifdef LU_ROW_STORE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [RW-1:0] model [SIZE];

  lu_row_store_if #(.SIZE(SIZE)) bus ();

  lu_row_store #(.SIZE(SIZE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start_i         = 1'b0;
    bus.in_row_i        = '0;
    bus.in_row_valid_i  = 1'b0;
    bus.rd_addr_i       = '0;
    bus.rd_addr_valid_i = 1'b0;
    bus.wr_row_i        = '0;
    bus.wr_row_valid_i  = 1'b0;
    bus.wr_addr_i       = '0;
    bus.lu_done_i       = 1'b0;
    bus.out_row_ready_i = 1'b0;
  endtask

  // Row k: elem[i].re = 10*k+i, random imaginary part.
  function automatic logic [RW-1:0] make_row(int k);
    logic [RW-1:0] r;
    for (int i = 0; i < SIZE; i++) begin
      r[i*128 +: 64]      = 64'(10 * k + i);
      r[i*128 + 64 +: 64] = {$urandom, $urandom};
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.busy_o, bus.in_row_ready_o, bus.wr_ready_o, bus.lu_start_o,
         bus.rd_row_valid_o, bus.out_row_valid_o} !== 6'b0) begin
      errors++;
      $display("FAIL %s_flags got %b exp 000000", name,
               {bus.busy_o, bus.in_row_ready_o, bus.wr_ready_o, bus.lu_start_o,
                bus.rd_row_valid_o, bus.out_row_valid_o});
    end
    checks++;
    if ({bus.rd_row_addr_o, bus.out_row_addr_o} !== '0 ||
        bus.rd_row_o !== '0 || bus.out_row_o !== '0) begin
      errors++;
      $display("FAIL %s_data got rd_addr=%0d out_addr=%0d rd_row_nz=%0b out_row_nz=%0b exp all 0",
               name, bus.rd_row_addr_o, bus.out_row_addr_o,
               (bus.rd_row_o != '0), (bus.out_row_o != '0));
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("post_reset");
  endtask

  task automatic do_load(input int base, input bit poke);
    int k;
    int cyc;
    bit acc;
    logic [RW-1:0] row;
    k   = 0;
    cyc = 0;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b1 || bus.in_row_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL load_enter got busy=%b ready=%b exp 1 1", bus.busy_o, bus.in_row_ready_o);
    end
    while (k < SIZE && cyc < 64) begin
      cyc++;
      row = make_row(k + base);
      bus.in_row_i        = row;
      bus.in_row_valid_i  = ($urandom_range(0, 3) != 0);
      bus.rd_addr_valid_i = poke;
      bus.rd_addr_i       = AW'($urandom);
      acc = bus.in_row_valid_i;
      checks++;
      if (bus.lu_start_o !== 1'b0 || bus.in_row_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL load_mid got lu_start=%b ready=%b exp 0 1", bus.lu_start_o, bus.in_row_ready_o);
      end
      step();
      if (acc) begin
        model[k] = row;
        k++;
      end
      if (poke) begin
        checks++;
        if (bus.rd_row_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL load_rd_ignored got %b exp 0", bus.rd_row_valid_o);
        end
      end
    end
    bus.in_row_valid_i  = 1'b0;
    bus.rd_addr_valid_i = 1'b0;
    checks++;
    if (k != SIZE) begin
      errors++;
      $display("FAIL load_timeout got %0d rows exp %0d", k, SIZE);
    end
    checks++;
    if ({bus.lu_start_o, bus.busy_o, bus.in_row_ready_o, bus.wr_ready_o} !== 4'b1101) begin
      errors++;
      $display("FAIL load_done got %b exp 1101",
               {bus.lu_start_o, bus.busy_o, bus.in_row_ready_o, bus.wr_ready_o});
    end
    step();
    checks++;
    if (bus.lu_start_o !== 1'b0) begin
      errors++;
      $display("FAIL lu_start_pulse got %b exp 0", bus.lu_start_o);
    end
  endtask

  task automatic test_load();
    do_load(0, 1'b0);
  endtask

  task automatic test_serve_read();
    bit v;
    logic [AW-1:0] a;
    bus.rd_addr_i       = 2'd2;
    bus.rd_addr_valid_i = 1'b1;
    step();
    bus.rd_addr_valid_i = 1'b0;
    checks++;
    if (bus.rd_row_valid_o !== 1'b1 || bus.rd_row_addr_o !== 2'd2 ||
        bus.rd_row_o[3*128 +: 64] !== 64'd23) begin
      errors++;
      $display("FAIL read_addr2 got v=%b a=%0d re3=%0d exp 1 2 23",
               bus.rd_row_valid_o, bus.rd_row_addr_o, bus.rd_row_o[3*128 +: 64]);
    end
    step();
    checks++;
    if (bus.rd_row_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL read_idle got %b exp 0", bus.rd_row_valid_o);
    end
    for (int c = 0; c < 16; c++) begin
      v = (c < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      a = AW'($urandom);
      bus.rd_addr_valid_i = v;
      bus.rd_addr_i       = a;
      step();
      checks++;
      if (bus.rd_row_valid_o !== v || (v && (bus.rd_row_addr_o !== a || bus.rd_row_o !== model[a]))) begin
        errors++;
        $display("FAIL read_b2b got v=%b a=%0d row=%h exp v=%b a=%0d row=%h",
                 bus.rd_row_valid_o, bus.rd_row_addr_o, bus.rd_row_o, v, a, model[a]);
      end
    end
    bus.rd_addr_valid_i = 1'b0;
  endtask

  task automatic test_collision();
    logic [RW-1:0] exp_row;
    exp_row = BYP ? '0 : model[1];
    bus.wr_row_i        = '0;
    bus.wr_addr_i       = 2'd1;
    bus.wr_row_valid_i  = 1'b1;
    bus.rd_addr_i       = 2'd1;
    bus.rd_addr_valid_i = 1'b1;
    checks++;
    if (bus.wr_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready got %b exp 1", bus.wr_ready_o);
    end
    step();
    bus.wr_row_valid_i = 1'b0;
    model[1] = '0;
    checks++;
    if (bus.rd_row_o !== exp_row || bus.rd_row_o[63:0] !== (BYP ? 64'd0 : 64'd10)) begin
      errors++;
      $display("FAIL collision got %h exp %h", bus.rd_row_o, exp_row);
    end
    step();
    bus.rd_addr_valid_i = 1'b0;
    checks++;
    if (bus.rd_row_valid_o !== 1'b1 || bus.rd_row_o !== '0) begin
      errors++;
      $display("FAIL after_write got v=%b row=%h exp 1 0", bus.rd_row_valid_o, bus.rd_row_o);
    end
  endtask

  task automatic test_serve_rw();
    bit rv, wv;
    logic [AW-1:0] ra, wa;
    logic [RW-1:0] wd, exp_row;
    for (int c = 0; c < 24; c++) begin
      rv = 1'($urandom_range(0, 1));
      wv = 1'($urandom_range(0, 1));
      ra = AW'($urandom);
      wa = ($urandom_range(0, 1) != 0) ? ra : AW'($urandom);
      wd = rand_row();
      exp_row = (rv && wv && ra == wa && BYP) ? wd : model[ra];
      bus.rd_addr_valid_i = rv;
      bus.rd_addr_i       = ra;
      bus.wr_row_valid_i  = wv;
      bus.wr_addr_i       = wa;
      bus.wr_row_i        = wd;
      step();
      if (wv) model[wa] = wd;
      checks++;
      if (bus.rd_row_valid_o !== rv || (rv && bus.rd_row_o !== exp_row)) begin
        errors++;
        $display("FAIL serve_rw got v=%b row=%h exp v=%b row=%h",
                 bus.rd_row_valid_o, bus.rd_row_o, rv, exp_row);
      end
    end
    bus.rd_addr_valid_i = 1'b0;
    bus.wr_row_valid_i  = 1'b0;
  endtask

  task automatic test_drain();
    int idx;
    int cyc;
    bit rdy, acc, held;
    logic [AW-1:0] held_addr;
    logic [RW-1:0] wd;
    wd = rand_row();
    bus.lu_done_i      = 1'b1;
    bus.wr_row_valid_i = 1'b1;
    bus.wr_addr_i      = 2'd3;
    bus.wr_row_i       = wd;
    step();
    model[3] = wd;
    bus.lu_done_i      = 1'b0;
    bus.wr_row_valid_i = 1'b0;
    checks++;
    if (bus.wr_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_enter got wr_ready=%b busy=%b exp 0 1", bus.wr_ready_o, bus.busy_o);
    end
    idx = 0;
    cyc = 0;
    held = 1'b0;
    held_addr = '0;
    while (idx < SIZE && cyc < 100) begin
      rdy = (cyc % 2 == 0);
      bus.out_row_ready_i = rdy;
      if (bus.out_row_valid_o) begin
        checks++;
        if (bus.out_row_addr_o !== AW'(idx) || bus.out_row_o !== model[idx]) begin
          errors++;
          $display("FAIL drain_row got a=%0d row=%h exp a=%0d row=%h",
                   bus.out_row_addr_o, bus.out_row_o, idx, model[idx]);
        end
      end
      if (held) begin
        checks++;
        if (bus.out_row_valid_o !== 1'b1 || bus.out_row_addr_o !== held_addr) begin
          errors++;
          $display("FAIL drain_hold got v=%b a=%0d exp 1 %0d",
                   bus.out_row_valid_o, bus.out_row_addr_o, held_addr);
        end
      end
      held      = bus.out_row_valid_o && !rdy;
      held_addr = bus.out_row_addr_o;
      acc       = bus.out_row_valid_o && rdy;
      step();
      cyc++;
      if (acc) idx++;
    end
    bus.out_row_ready_i = 1'b0;
    checks++;
    if (idx != SIZE) begin
      errors++;
      $display("FAIL drain_timeout got %0d rows exp %0d", idx, SIZE);
    end
    checks++;
    if (bus.busy_o !== 1'b0 || bus.out_row_valid_o !== 1'b0 || bus.out_row_addr_o !== '0) begin
      errors++;
      $display("FAIL drain_exit got busy=%b v=%b a=%0d exp 0 0 0",
               bus.busy_o, bus.out_row_valid_o, bus.out_row_addr_o);
    end
  endtask

  task automatic test_abort();
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_row_i       = make_row(k + 7);
      bus.in_row_valid_i = 1'b1;
      step();
    end
    #2;
    rst = 1'b1;
    bus.in_row_valid_i = 1'b0;
    #1;
    check_all_zero("abort");
    step();
    rst = 1'b0;
    step();
    check_all_zero("abort_idle");
  endtask

  task automatic test_ignored();
    do_load(5, 1'b1);
    bus.rd_addr_i       = 2'd0;
    bus.rd_addr_valid_i = 1'b1;
    bus.start_i         = 1'b1;
    step();
    bus.rd_addr_valid_i = 1'b0;
    bus.start_i         = 1'b0;
    checks++;
    if (bus.rd_row_o !== model[0] || bus.rd_row_o[63:0] !== 64'd50) begin
      errors++;
      $display("FAIL reload_row0 got %0d exp 50", bus.rd_row_o[63:0]);
    end
    step();
    checks++;
    if ({bus.busy_o, bus.in_row_ready_o, bus.wr_ready_o, bus.lu_start_o} !== 4'b1010) begin
      errors++;
      $display("FAIL start_ignored got %b exp 1010",
               {bus.busy_o, bus.in_row_ready_o, bus.wr_ready_o, bus.lu_start_o});
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_serve_read();
    test_collision();
    test_serve_rw();
    test_drain();
    test_abort();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
